// File: rtl/fft_pkg.sv
// Shared types and constants for the spectrum front end and FFT interface.
package fft_pkg;

    localparam int FFT_N   = 16;
    localparam int SAT_MAX = 511;
    localparam int SAT_MIN = -512;

    typedef logic signed [23:0] fft_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        PENDING
    } fb_state_t;

endpackage

// File: rtl/sample_conditioner.sv
// Combinational shift, saturate and fixed-point format of one audio sample.
module sample_conditioner
    import fft_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int SHIFT = 6
) (
    input  logic signed [IN_W-1:0] sample_i,
    output fft_sample_t            word_o
);

    logic signed [31:0] w_ext;
    logic signed [31:0] w_shift;
    logic signed [15:0] w_sat;

    always_comb begin
        w_ext   = {{(32-IN_W){sample_i[IN_W-1]}}, sample_i};
        w_shift = w_ext >>> SHIFT;
        if (w_shift > SAT_MAX) begin
            w_sat = 16'(SAT_MAX);
        end else if (w_shift < SAT_MIN) begin
            w_sat = 16'(SAT_MIN);
        end else begin
            w_sat = w_shift[15:0];
        end
        word_o = {w_sat, 8'h00};
    end

endmodule

// File: rtl/audio_frame_buffer.sv
// Decimates and conditions audio samples into 16-sample frames, double-buffered
// towards the FFT with a hold bank and a sticky overrun flag.
module audio_frame_buffer
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int IN_W  = 16,
    parameter int SHIFT = 6,
    parameter int DECIM = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] sample_i,
    input  logic                   sample_valid_i,
    input  logic                   fft_done_i,
    output fft_sample_t            t_o [N],
    output logic                   new_t_o,
    output logic                   overrun_o
);

    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int IW  = $clog2(N);

    logic [DCW-1:0] r_dcnt;
    logic [IW-1:0]  r_wr_idx;
    logic           r_frame_rdy;
    logic           r_done_q;
    fb_state_t      r_state;
    fft_sample_t    r_fill [N];
    fft_sample_t    r_hold [N];

    fft_sample_t    w_word;
    logic           w_accept;
    logic           w_done_rise;

    sample_conditioner #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT)
    ) u_cond (
        .sample_i (sample_i),
        .word_o   (w_word)
    );

    assign w_accept    = sample_valid_i && (r_dcnt == '0);
    assign w_done_rise = fft_done_i && !r_done_q && !new_t_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dcnt      <= '0;
            r_wr_idx    <= '0;
            r_frame_rdy <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_done_q    <= fft_done_i;
            r_frame_rdy <= w_accept && (r_wr_idx == IW'(N-1));
            if (sample_valid_i) begin
                r_dcnt <= (r_dcnt == DCW'(DECIM-1)) ? '0 : r_dcnt + 1'b1;
            end
            if (w_accept) begin
                r_wr_idx <= (r_wr_idx == IW'(N-1)) ? '0 : r_wr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            r_fill[r_wr_idx] <= w_word;
        end
    end

    // Frames are taken from r_fill one cycle after completion; a write to
    // index 0 in that same cycle lands after the copy has sampled r_fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            t_o       <= '{default: '0};
            new_t_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            new_t_o <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_frame_rdy) begin
                        t_o     <= r_fill;
                        new_t_o <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_frame_rdy && w_done_rise) begin
                        t_o     <= r_fill;
                        new_t_o <= 1'b1;
                    end else if (r_frame_rdy) begin
                        r_hold  <= r_fill;
                        r_state <= PENDING;
                    end else if (w_done_rise) begin
                        r_state <= IDLE;
                    end
                end
                PENDING: begin
                    if (w_done_rise) begin
                        t_o     <= r_hold;
                        new_t_o <= 1'b1;
                        if (r_frame_rdy) begin
                            r_hold <= r_fill;
                        end else begin
                            r_state <= BUSY;
                        end
                    end else if (r_frame_rdy) begin
                        r_hold    <= r_fill;
                        overrun_o <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: three instances cover SHIFT=6, SHIFT=0
// saturation boundaries and DECIM=4.
module tb_audio_frame_buffer;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] smp  [3];
    logic        vld  [3];
    logic        done [3];
    logic        newt [3];
    logic        ovr  [3];
    fft_sample_t t_a  [16];
    fft_sample_t t_b  [16];
    fft_sample_t t_c  [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    audio_frame_buffer #(.N(16), .IN_W(16), .SHIFT(6), .DECIM(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .sample_i(smp[0]), .sample_valid_i(vld[0]),
        .fft_done_i(done[0]), .t_o(t_a), .new_t_o(newt[0]), .overrun_o(ovr[0])
    );

    audio_frame_buffer #(.N(16), .IN_W(16), .SHIFT(0), .DECIM(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .sample_i(smp[1]), .sample_valid_i(vld[1]),
        .fft_done_i(done[1]), .t_o(t_b), .new_t_o(newt[1]), .overrun_o(ovr[1])
    );

    audio_frame_buffer #(.N(16), .IN_W(16), .SHIFT(0), .DECIM(4)) u_dut2 (
        .clk(clk), .reset(rst_n), .sample_i(smp[2]), .sample_valid_i(vld[2]),
        .fft_done_i(done[2]), .t_o(t_c), .new_t_o(newt[2]), .overrun_o(ovr[2])
    );

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic fft_sample_t get_t(input int d, input int k);
        case (d)
            0:       return t_a[k];
            1:       return t_b[k];
            default: return t_c[k];
        endcase
    endfunction

    task automatic send(input int d, input logic [15:0] v);
        @(negedge clk);
        vld[d] = 1'b1;
        smp[d] = v;
    endtask

    // Called right after the 16th accepted sample has been driven.
    task automatic pulse_chk(input string tag, input int d, input logic exp_pulse);
        @(negedge clk);
        vld[d] = 1'b0;
        chk({tag, "_pre"}, 24'(newt[d]), 24'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 24'(newt[d]), 24'(exp_pulse));
        @(negedge clk);
        chk({tag, "_post"}, 24'(newt[d]), 24'd0);
    endtask

    task automatic frame_chk(input string tag, input int d, input int base, input int step);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s[%0d]", tag, k), get_t(d, k), 24'((base + step * k) * 256));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            smp[d]  = '0;
            vld[d]  = 1'b0;
            done[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        frame_chk("rst_t", 0, 0, 0);
        chk("rst_new", 24'(newt[0]), 24'd0);
        chk("rst_ovr", 24'(ovr[0]), 24'd0);

        // Frame 1: full-scale positive saturates to 511.
        for (int k = 0; k < 16; k++) send(0, 16'h7FFF);
        pulse_chk("f1", 0, 1'b1);
        frame_chk("f1_t", 0, 511, 0);

        // Frame 2 goes to the hold bank while the FFT is busy.
        for (int k = 0; k < 16; k++) send(0, 16'(k * 64));
        pulse_chk("f2", 0, 1'b0);
        chk("f2_t_stable", t_a[5], 24'h01FF00);
        chk("f2_ovr", 24'(ovr[0]), 24'd0);

        // Frame 3 replaces the pending frame and flags overrun.
        for (int k = 0; k < 16; k++) send(0, 16'(-(k * 64)));
        pulse_chk("f3", 0, 1'b0);
        chk("f3_ovr", 24'(ovr[0]), 24'd1);
        chk("f3_t_stable", t_a[5], 24'h01FF00);

        // done rise publishes the newest (third) frame.
        @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        chk("pub3_new", 24'(newt[0]), 24'd1);
        frame_chk("pub3_t", 0, 0, -1);
        @(negedge clk);
        chk("pub3_post", 24'(newt[0]), 24'd0);
        chk("pub3_ovr_sticky", 24'(ovr[0]), 24'd1);

        // done stays high: the next frame must still be held, not published.
        for (int k = 0; k < 16; k++) send(0, 16'h1000);
        pulse_chk("f4", 0, 1'b0);
        chk("f4_t_stable", t_a[1], 24'hFFFF00);
        @(negedge clk);
        done[0] = 1'b0;
        @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        chk("pub4_new", 24'(newt[0]), 24'd1);
        frame_chk("pub4_t", 0, 64, 0);

        // A fresh rise with nothing pending returns to IDLE.
        @(negedge clk);
        done[0] = 1'b0;
        @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        chk("idle_new", 24'(newt[0]), 24'd0);
        for (int k = 0; k < 16; k++) send(0, 16'h2000);
        pulse_chk("f5", 0, 1'b1);
        frame_chk("f5_t", 0, 128, 0);

        // Mid-frame reset discards the partial frame.
        done[0] = 1'b0;
        for (int k = 0; k < 9; k++) send(0, 16'h0040);
        @(negedge clk);
        vld[0] = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        frame_chk("rst2_t", 0, 0, 0);
        chk("rst2_new", 24'(newt[0]), 24'd0);
        chk("rst2_ovr", 24'(ovr[0]), 24'd0);
        for (int k = 0; k < 16; k++) send(0, 16'((k + 1) * 64));
        pulse_chk("f6", 0, 1'b1);
        frame_chk("f6_t", 0, 1, 1);

        // SHIFT=0 saturation boundaries.
        send(1, 16'h8000);
        send(1, 16'hFFE0);
        send(1, 16'd511);
        send(1, 16'd512);
        send(1, 16'hFDFF);
        send(1, 16'h7FFF);
        for (int k = 6; k < 16; k++) send(1, 16'(k));
        pulse_chk("s0", 1, 1'b1);
        chk("s0_t0", t_b[0], 24'hFE0000);
        chk("s0_t1", t_b[1], 24'hFFE000);
        chk("s0_t2", t_b[2], 24'h01FF00);
        chk("s0_t3", t_b[3], 24'h01FF00);
        chk("s0_t4", t_b[4], 24'hFE0000);
        chk("s0_t5", t_b[5], 24'h01FF00);
        for (int k = 6; k < 16; k++) begin
            chk($sformatf("s0_t%0d", k), t_b[k], 24'(k * 256));
        end

        // DECIM=4 with idle gaps that must not advance the decimator.
        for (int i = 0; i <= 60; i++) begin
            if (i % 8 == 3) begin
                @(negedge clk);
                vld[2] = 1'b0;
            end
            send(2, 16'(i));
        end
        pulse_chk("d4", 2, 1'b1);
        frame_chk("d4_t", 2, 0, 4);
        for (int i = 61; i < 64; i++) send(2, 16'(i));
        @(negedge clk);
        vld[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("d4_tail_new", 24'(newt[2]), 24'd0);
        chk("d4_tail_t", t_c[15], 24'h003C00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
